// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed six-digit seven-segment display driver:
// digit count, the din word layout, the segment code table and the types
// used to carry one slot's worth of display outputs.
package seg7_pkg;

    // Number of multiplexed digits on the display.
    localparam int NUM_DIGITS = 6;

    // Width of one digit code inside the din word.
    localparam int CODE_W = 4;

    // din field offsets: digit k code lives at [4k+3:4k].
    localparam int DIN_CODE_LSB   = 0;
    localparam int DIN_BLINK_LSB  = 24;
    localparam int DIN_COLON_BIT  = 30;
    localparam int DIN_ENABLE_BIT = 31;

    // Active-low "everything off" values.
    localparam logic [6:0]            SEG_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = '1;

    // Segment code table, active-low, bit order gfedcba.
    // Entry 0 is the rightmost element of the concatenation.
    //   0..9 : numerals, A : '-', B..F : blank.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h7F,  // F blank
        7'h7F,  // E blank
        7'h7F,  // D blank
        7'h7F,  // C blank
        7'h7F,  // B blank
        7'h3F,  // A '-'
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // One slot's registered display outputs, kept together so the next-value
    // logic and the output register stay in step.
    typedef struct packed {
        logic [6:0]            seg_n;
        logic                  dp_n;
        logic [NUM_DIGITS-1:0] dig_en_n;
    } disp_t;

    // Display outputs for a dark (disabled or reset) display.
    localparam disp_t DISP_DARK = '{seg_n: SEG_BLANK, dp_n: 1'b1, dig_en_n: DIG_OFF};

    // Pull the code for digit idx out of a din word.
    function automatic logic [CODE_W-1:0] digit_code(input logic [31:0] word,
                                                     input logic [2:0]  idx);
        logic [31:0] shifted;
        shifted = word >> (DIN_CODE_LSB + CODE_W * int'(idx));
        return shifted[CODE_W-1:0];
    endfunction

    // Blink mask bit for digit idx.
    function automatic logic blink_bit(input logic [31:0] word,
                                       input logic [2:0]  idx);
        logic [31:0] shifted;
        shifted = word >> (DIN_BLINK_LSB + int'(idx));
        return shifted[0];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-seven-segment decoder, active-low outputs (gfedcba).
// Codes 0-9 are numerals, A is a dash, B-F are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_n
);

    // Straight table lookup; the table lives in the package.
    always_comb begin
        seg_n = SEG_TABLE[code];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a six-digit common-anode seven-segment display.
// A prescaler produces one slot tick every SCAN_DIV clocks; each tick moves
// to the next digit. The display word is snapshotted once per frame (when the
// digit index wraps 5->0) so a word rewritten mid-frame never tears. All
// outputs are registered and only change on the cycle after a tick.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           din,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] dig_en_n,
    output logic                  frame_strobe
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [2:0]         IDX_LAST   = 3'(NUM_DIGITS - 1);

    // Counter and frame state.
    logic [PRESC_W-1:0] presc;
    logic [2:0]         idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [31:0]        snapshot;

    // Next-state and next-output signals.
    logic               tick;
    logic               wrap;
    logic               blink_wrap;
    logic [2:0]         idx_next;
    logic               phase_next;
    logic [31:0]        frame_src;
    logic [3:0]         code_next;
    logic [6:0]         seg_dec;
    disp_t              disp_next;
    disp_t              disp_q;

    // Slot tick, frame wrap and blink wrap detection, plus the values the
    // index and phase take after this tick.
    always_comb begin
        tick       = (presc == PRESC_LAST);
        wrap       = tick && (idx == IDX_LAST);
        blink_wrap = tick && (blink_cnt == BLINK_LAST);
        idx_next   = (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        phase_next = blink_phase ^ blink_wrap;
        // On a wrap the freshly captured word is what the new slot shows.
        frame_src  = wrap ? din : snapshot;
        code_next  = digit_code(frame_src, idx_next);
    end

    seg7_decode u_decode (
        .code  (code_next),
        .seg_n (seg_dec)
    );

    // Output values for the slot being entered. Blinked digits keep their
    // digit enable asserted but show nothing; a disabled display is fully dark.
    // The blink phase used is the one in force after this tick.
    always_comb begin
        disp_next = DISP_DARK;
        if (frame_src[DIN_ENABLE_BIT]) begin
            disp_next.dig_en_n = ~(NUM_DIGITS'(1) << idx_next);
            if (phase_next && blink_bit(frame_src, idx_next)) begin
                disp_next.seg_n = SEG_BLANK;
                disp_next.dp_n  = 1'b1;
            end else begin
                disp_next.seg_n = seg_dec;
                disp_next.dp_n  = ~(frame_src[DIN_COLON_BIT] &&
                                    ((idx_next == 3'd2) || (idx_next == 3'd4)));
            end
        end
    end

    // Prescaler: free-running 0..SCAN_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Digit index and blink phase advance once per slot tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            idx         <= idx_next;
            blink_cnt   <= blink_wrap ? '0 : blink_cnt + BLINK_W'(1);
            blink_phase <= phase_next;
        end
    end

    // Frame snapshot of din, taken only when the index wraps to digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
        end else if (wrap) begin
            snapshot <= din;
        end
    end

    // Registered display outputs and the one-cycle frame start pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q       <= DISP_DARK;
            frame_strobe <= 1'b0;
        end else begin
            frame_strobe <= wrap;
            if (tick) begin
                disp_q <= disp_next;
            end
        end
    end

    assign seg_n    = disp_q.seg_n;
    assign dp_n     = disp_q.dp_n;
    assign dig_en_n = disp_q.dig_en_n;

endmodule
